// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and defaults.
package uart_pkg;

    localparam logic [1:0] ARB_IDLE      = 2'd0;
    localparam logic [1:0] ARB_START     = 2'd1;
    localparam logic [1:0] ARB_WAIT_DONE = 2'd2;

    localparam int unsigned UART_DATA_W         = 8;
    localparam int unsigned UART_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE      = ARB_IDLE,
        ST_START     = ARB_START,
        ST_WAIT_DONE = ARB_WAIT_DONE
    } arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter.
// timeout_err exists only when UART_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = UART_DATA_W
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic                      tx_done;
    logic [IDX_W-1:0]          grant_id;
    logic                      arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic                      timeout_err;
`endif

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_data, tx_start, grant_id, arb_busy
`ifdef UART_ARB_TIMEOUT_EN
       ,input  timeout_err
`endif
    );

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_data, tx_start, grant_id, arb_busy
`ifdef UART_ARB_TIMEOUT_EN
       ,output timeout_err
`endif
    );

endinterface : uart_tx_arbiter_if

// File: rtl/uart_rr_picker.sv
// Rotating-priority picker: first set request at or after ptr_i, with wrap.
module uart_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Walk the requests starting from the pointer, keep the first hit.
    always_comb begin
        int unsigned      pos;
        logic [IDX_W-1:0] cand;
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(ptr_i) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule : uart_rr_picker

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional build macro: UART_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog and the
// sticky timeout_err flag.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = UART_DATA_W
`ifdef UART_ARB_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
`endif
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
`endif

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q;
    logic                arb_busy_q;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Unpack the flat request data bus into per-requester bytes.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Priority restarts just after the requester that was last served.
    always_comb begin
        next_ptr = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
    end

    // Next-state logic; req_ready is the only combinational output.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        tx_data_d   = tx_data_q;
        req_ready_c = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.tx_busy && pick_found) begin
                    req_ready_c = NUM_REQ'(1) << pick_idx;
                    tx_data_d   = req_bytes[pick_idx];
                    grant_id_d  = pick_idx;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            arb_busy_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= (state_d == ST_START);
            arb_busy_q <= (state_d != ST_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.arb_busy  = arb_busy_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`endif

endmodule : uart_tx_arbiter
